demux_1_to_2: RTL and testbench
===============================

DEMUX_1_TO_2 -- requirements
Module: demux_1_to_2

Interface
REQ-001 Parameter WIDTH, default 1: data width of in, a, b, a_q, b_q.
REQ-002 Parameter CNT_W, default 16: width of the routing counters cnt_a and cnt_b.
REQ-003 clk  input  1  single clock; all sequential logic on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in  input  WIDTH  data to be routed.
REQ-006 sel  input  1  route select: 0 = output a, 1 = output b.
REQ-007 clr  input  1  synchronous clear of the counters, active-high.
REQ-008 a  output  WIDTH  combinational routed output, channel 0.
REQ-009 b  output  WIDTH  combinational routed output, channel 1.
REQ-010 a_q  output  WIDTH  registered copy of a.
REQ-011 b_q  output  WIDTH  registered copy of b.
REQ-012 cnt_a  output  CNT_W  saturating count of cycles with a nonzero.
REQ-013 cnt_b  output  CNT_W  saturating count of cycles with b nonzero.

Function
REQ-014 a SHALL equal in when sel=0, else all zeros; purely combinational, zero latency, independent of clk and rst_n.
REQ-015 b SHALL equal in when sel=1, else all zeros; purely combinational, zero latency, independent of clk and rst_n.
REQ-016 a and b SHALL never both be nonzero in the same instant.
REQ-017 Truth table for WIDTH=1 (in, sel -> a, b): 0,0->0,0; 0,1->0,0; 1,0->1,0; 1,1->0,1.
REQ-018 a_q and b_q SHALL load a and b on every rising clk edge when rst_n=1: one-cycle latency.
REQ-019 On a rising edge with rst_n=1 and clr=0, cnt_a SHALL increment by 1 if a is nonzero, and cnt_b SHALL increment by 1 if b is nonzero.
REQ-020 Counters SHALL saturate at 2^CNT_W-1 and hold that value; they SHALL NOT wrap.
REQ-021 clr=1 SHALL zero both counters on the next edge and take priority over increment in the same cycle.
REQ-022 X/Z on sel is not a supported input; the implementation's behaviour in that case is left unconstrained.

Reset
REQ-023 On a rising edge with rst_n=0: a_q=0, b_q=0, cnt_a=0, cnt_b=0.
REQ-024 Reset SHALL take priority over clr and over increment.
REQ-025 Reset SHALL NOT affect the combinational outputs a and b.
REQ-026 Reset asserted mid-operation SHALL clear all state at that edge; normal operation resumes on the first edge with rst_n=1.

Structure
REQ-027 Package demux_pkg SHALL hold the default constants DEMUX_WIDTH_DEF=1 and DEMUX_CNT_W_DEF=16, plus the channel-index constants CH_A=0 and CH_B=1.
REQ-028 The design SHALL contain one sub-module, sat_counter (parameter CNT_W; ports clk, rst_n, clr, inc, count).
REQ-029 sat_counter SHALL be instantiated twice: once for cnt_a and once for cnt_b.

Verification
REQ-030 Combinational sweep, WIDTH=1, no clock edges, 10 time units per step: in/sel = 0/0, 0/1, 1/0, 1/1 -> a/b = 0/0, 0/0, 1/0, 0/1.
REQ-031 Reset: hold rst_n=0 for 2 edges with in=1, sel=0 -> a_q=0, b_q=0, cnt_a=0, cnt_b=0, while a=1.
REQ-032 Counting: after reset, drive in=1, sel=0 for 3 edges, then sel=1 for 2 edges -> cnt_a=3, cnt_b=2; b_q=1 one cycle after sel rises.
REQ-033 Saturation: CNT_W=2, drive in=1, sel=1 for 6 edges -> cnt_b=3 and holds at 3.
REQ-034 Clear priority: clr=1 while in=1, sel=0 -> cnt_a=0 after that edge; with rst_n=0 and clr=1 together -> all state 0.
REQ-035 Wide data: WIDTH=8, in=8'hA5, sel=1 -> a=8'h00, b=8'hA5; b_q=8'hA5 after one edge.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 demux: default sizes and channel indices.
package demux_pkg;

  localparam int DEMUX_WIDTH_DEF = 1;
  localparam int DEMUX_CNT_W_DEF = 16;

  // Channel indices into the routed-output arrays
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int NUM_CH = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = demux_pkg::DEMUX_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Reset beats clear, clear beats increment; hold once saturated
  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/demux_1_to_2.sv
// 1-to-2 demux: combinational routing, registered copies, and per-channel
// saturating counts of cycles in which each routed output is nonzero.
module demux_1_to_2
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF,
  parameter int CNT_W = DEMUX_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  input  logic             clr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic [NUM_CH-1:0][WIDTH-1:0] route;
  logic [NUM_CH-1:0][WIDTH-1:0] route_q;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;

  // Exactly one channel can carry data, so a and b are never both nonzero
  always_comb begin
    route       = '0;
    route[CH_A] = sel ? '0 : in;
    route[CH_B] = sel ? in : '0;
  end

  // One-cycle registered copy of both routed outputs
  always_ff @(posedge clk) begin
    if (!rst_n)
      route_q <= '0;
    else
      route_q <= route;
  end

  // One activity counter per channel, bumped whenever that channel is nonzero
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (|route[g]),
      .count (cnt[g])
    );
  end

  assign a     = route[CH_A];
  assign b     = route[CH_B];
  assign a_q   = route_q[CH_A];
  assign b_q   = route_q[CH_B];
  assign cnt_a = cnt[CH_A];
  assign cnt_b = cnt[CH_B];

endmodule

// File: tb/tb_demux_1_to_2.sv
// Scoreboard bench for demux_1_to_2: three instances (1-bit/16-bit counters,
// 1-bit/2-bit counters, 8-bit/16-bit counters) driven from directed vectors.
module tb_demux_1_to_2;

  logic clk = 1'b0;
  bit   clk_en = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  logic rst_n, clr;
  logic in1, sel1, in2, sel2, sel8;
  logic [7:0] in8;

  logic a1, b1, aq1, bq1;
  logic [15:0] ca1, cb1;
  logic a2, b2, aq2, bq2;
  logic [1:0] ca2, cb2;
  logic [7:0] a8, b8, aq8, bq8;
  logic [15:0] ca8, cb8;

  demux_1_to_2 #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel1), .clr(clr),
    .a(a1), .b(b1), .a_q(aq1), .b_q(bq1), .cnt_a(ca1), .cnt_b(cb1));

  demux_1_to_2 #(.WIDTH(1), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in(in2), .sel(sel2), .clr(clr),
    .a(a2), .b(b2), .a_q(aq2), .b_q(bq2), .cnt_a(ca2), .cnt_b(cb2));

  demux_1_to_2 #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .clr(clr),
    .a(a8), .b(b8), .a_q(aq8), .b_q(bq8), .cnt_a(ca8), .cnt_b(cb8));

  typedef struct {
    int          inst;
    bit          full;   // 0: only combinational a/b are defined
    logic [7:0]  a, b, aq, bq;
    logic [15:0] ca, cb;
    string       tag;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string tag, input string f, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h", tag, f, act, exp);
    end
  endtask

  task automatic push(input int inst, input bit full, input logic [7:0] ea, input logic [7:0] eb,
                      input logic [7:0] eaq, input logic [7:0] ebq,
                      input logic [15:0] eca, input logic [15:0] ecb, input string tag);
    exp_t e;
    e.inst = inst; e.full = full; e.a = ea; e.b = eb; e.aq = eaq; e.bq = ebq;
    e.ca = eca; e.cb = ecb; e.tag = tag;
    sb.push_back(e);
  endtask

  // Release the monitor, then let it sample before inputs move
  task automatic go();
    -> chk_ev;
    #1;
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  // Monitor: drains the scoreboard whenever stimulus flags a sample point
  initial begin
    exp_t e;
    logic [7:0]  xa, xb, xqa, xqb;
    logic [15:0] xca, xcb;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.inst)
          0: begin
            xa = {7'b0, a1}; xb = {7'b0, b1}; xqa = {7'b0, aq1}; xqb = {7'b0, bq1};
            xca = ca1; xcb = cb1;
          end
          1: begin
            xa = {7'b0, a2}; xb = {7'b0, b2}; xqa = {7'b0, aq2}; xqb = {7'b0, bq2};
            xca = {14'b0, ca2}; xcb = {14'b0, cb2};
          end
          default: begin
            xa = a8; xb = b8; xqa = aq8; xqb = bq8; xca = ca8; xcb = cb8;
          end
        endcase
        cmp(e.tag, "a", 16'(xa), 16'(e.a));
        cmp(e.tag, "b", 16'(xb), 16'(e.b));
        if (e.full) begin
          cmp(e.tag, "a_q", 16'(xqa), 16'(e.aq));
          cmp(e.tag, "b_q", 16'(xqb), 16'(e.bq));
          cmp(e.tag, "cnt_a", xca, e.ca);
          cmp(e.tag, "cnt_b", xcb, e.cb);
        end
      end
    end
  end

  // Stimulus
  initial begin
    bit vin[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit vsel[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit va[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit vb[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; clr = 1'b0;
    in1 = 1'b0; sel1 = 1'b0;
    in2 = 1'b1; sel2 = 1'b1;
    in8 = 8'hA5; sel8 = 1'b1;

    // Combinational truth table, clock stopped
    for (int i = 0; i < 4; i++) begin
      in1 = vin[i]; sel1 = vsel[i];
      #5;
      push(0, 1'b0, 8'(va[i]), 8'(vb[i]), 8'h0, 8'h0, 16'h0, 16'h0, $sformatf("comb%0d", i));
      go();
      #4;
    end

    // Reset for two edges; combinational outputs unaffected
    in1 = 1'b1; sel1 = 1'b0;
    clk_en = 1'b1;
    edge_(); edge_();
    push(0, 1'b1, 8'h1, 8'h0, 8'h0, 8'h0, 16'd0, 16'd0, "rst_u1");
    push(1, 1'b1, 8'h0, 8'h1, 8'h0, 8'h0, 16'd0, 16'd0, "rst_u2");
    push(2, 1'b1, 8'h0, 8'hA5, 8'h0, 8'h0, 16'd0, 16'd0, "rst_u8");
    go();

    // Counting: sel1=0 for 3 edges, then sel1=1; u2 saturates at 3
    rst_n = 1'b1;
    edge_();
    push(0, 1'b1, 8'h1, 8'h0, 8'h1, 8'h0, 16'd1, 16'd0, "cnt1_u1");
    push(1, 1'b1, 8'h0, 8'h1, 8'h0, 8'h1, 16'd0, 16'd1, "sat1_u2");
    push(2, 1'b1, 8'h0, 8'hA5, 8'h0, 8'hA5, 16'd0, 16'd1, "wide1_u8");
    go();
    edge_();
    push(0, 1'b1, 8'h1, 8'h0, 8'h1, 8'h0, 16'd2, 16'd0, "cnt2_u1");
    push(1, 1'b1, 8'h0, 8'h1, 8'h0, 8'h1, 16'd0, 16'd2, "sat2_u2");
    go();
    edge_();
    push(0, 1'b1, 8'h1, 8'h0, 8'h1, 8'h0, 16'd3, 16'd0, "cnt3_u1");
    push(1, 1'b1, 8'h0, 8'h1, 8'h0, 8'h1, 16'd0, 16'd3, "sat3_u2");
    go();
    sel1 = 1'b1;
    edge_();
    push(0, 1'b1, 8'h0, 8'h1, 8'h0, 8'h1, 16'd3, 16'd1, "cnt4_u1");
    push(1, 1'b1, 8'h0, 8'h1, 8'h0, 8'h1, 16'd0, 16'd3, "sat4_u2");
    go();
    edge_();
    push(0, 1'b1, 8'h0, 8'h1, 8'h0, 8'h1, 16'd3, 16'd2, "cnt5_u1");
    push(1, 1'b1, 8'h0, 8'h1, 8'h0, 8'h1, 16'd0, 16'd3, "sat5_u2");
    go();
    edge_();
    push(0, 1'b1, 8'h0, 8'h1, 8'h0, 8'h1, 16'd3, 16'd3, "cnt6_u1");
    push(1, 1'b1, 8'h0, 8'h1, 8'h0, 8'h1, 16'd0, 16'd3, "sat6_u2");
    push(2, 1'b1, 8'h0, 8'hA5, 8'h0, 8'hA5, 16'd0, 16'd6, "wide6_u8");
    go();

    // Clear wins over increment
    sel1 = 1'b0; clr = 1'b1;
    edge_();
    push(0, 1'b1, 8'h1, 8'h0, 8'h1, 8'h0, 16'd0, 16'd0, "clr_u1");
    push(1, 1'b1, 8'h0, 8'h1, 8'h0, 8'h1, 16'd0, 16'd0, "clr_u2");
    push(2, 1'b1, 8'h0, 8'hA5, 8'h0, 8'hA5, 16'd0, 16'd0, "clr_u8");
    go();
    clr = 1'b0;
    edge_();
    push(0, 1'b1, 8'h1, 8'h0, 8'h1, 8'h0, 16'd1, 16'd0, "postclr_u1");
    go();

    // Reset together with clear mid-operation, then resume
    rst_n = 1'b0; clr = 1'b1;
    edge_();
    push(0, 1'b1, 8'h1, 8'h0, 8'h0, 8'h0, 16'd0, 16'd0, "rstclr_u1");
    push(1, 1'b1, 8'h0, 8'h1, 8'h0, 8'h0, 16'd0, 16'd0, "rstclr_u2");
    push(2, 1'b1, 8'h0, 8'hA5, 8'h0, 8'h0, 16'd0, 16'd0, "rstclr_u8");
    go();
    rst_n = 1'b1; clr = 1'b0;
    edge_();
    push(0, 1'b1, 8'h1, 8'h0, 8'h1, 8'h0, 16'd1, 16'd0, "resume_u1");
    push(2, 1'b1, 8'h0, 8'hA5, 8'h0, 8'hA5, 16'd0, 16'd1, "resume_u8");
    go();

    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
